// File: rtl/shared_phase_scheduler.sv
// One PHASE_W-bit phase adder time-shared round-robin across NUM_CH channels.
// Define SHARED_PHASE_FRAME_STB_EN to add the per-round o_frame_stb output.
module shared_phase_scheduler #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned PHASE_W = 32
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [NUM_CH*PHASE_W-1:0]     i_phase_delta,
   input  logic [NUM_CH-1:0]             i_delta_valid,
   input  logic [NUM_CH-1:0]             i_enable,
   input  logic [NUM_CH-1:0]             i_sync,
   output logic [PHASE_W-1:0]            o_phase,
   output logic [$clog2(NUM_CH)-1:0]     o_phase_ch,
   output logic                          o_phase_valid,
`ifdef SHARED_PHASE_FRAME_STB_EN
   output logic [NUM_CH-1:0]             o_wrap_stb,
   output logic                          o_frame_stb
`else
   output logic [NUM_CH-1:0]             o_wrap_stb
`endif
);

   localparam int unsigned CH_W = $clog2(NUM_CH);

   logic [CH_W-1:0]    slot;
   logic [PHASE_W-1:0] phase [NUM_CH];
   logic [PHASE_W-1:0] delta [NUM_CH];
   logic [NUM_CH-1:0]  pend_sync;

   logic               sync_now;
   logic               en_now;
   logic               carry;
   logic [PHASE_W-1:0] sum;
   logic [PHASE_W-1:0] phase_next;
   logic [NUM_CH-1:0]  slot_hot;
   logic [NUM_CH-1:0]  wrap_next;

   // A sync arriving in the channel's own slot is honoured immediately and beats the add.
   always_comb begin
      slot_hot         = '0;
      slot_hot[slot]   = 1'b1;
      sync_now         = pend_sync[slot] | i_sync[slot];
      en_now           = i_enable[slot];
      {carry, sum}     = {1'b0, phase[slot]} + {1'b0, delta[slot]};
      phase_next       = phase[slot];
      wrap_next        = '0;
      if (sync_now) begin
         phase_next = '0;
      end else if (en_now) begin
         phase_next = sum;
         wrap_next  = carry ? slot_hot : '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         slot          <= '0;
         pend_sync     <= '0;
         o_phase       <= '0;
         o_phase_ch    <= '0;
         o_phase_valid <= 1'b0;
         o_wrap_stb    <= '0;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            phase[c] <= '0;
            delta[c] <= '0;
         end
      end else begin
         slot        <= (slot == CH_W'(NUM_CH - 1)) ? '0 : slot + 1'b1;
         phase[slot] <= phase_next;
         pend_sync   <= (pend_sync | i_sync) & ~(sync_now ? slot_hot : '0);
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (i_delta_valid[c]) delta[c] <= i_phase_delta[c*PHASE_W +: PHASE_W];
         end
         o_phase_valid <= en_now;
         o_wrap_stb    <= wrap_next;
         // Disabled slots leave the last reported phase/channel on the bus.
         if (en_now) begin
            o_phase    <= phase_next;
            o_phase_ch <= slot;
         end
      end
   end

`ifdef SHARED_PHASE_FRAME_STB_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_frame_stb <= 1'b0;
      else          o_frame_stb <= (slot == '0);
   end
`endif

endmodule

// File: tb/tb_shared_phase_scheduler.sv
// Randomised and directed bench for shared_phase_scheduler against a per-channel arithmetic model.
module tb_shared_phase_scheduler;

   localparam int NUM_CH  = 4;
   localparam int PHASE_W = 32;

   logic                      i_clk = 1'b0;
   logic                      i_rst_n;
   logic [NUM_CH*PHASE_W-1:0] i_phase_delta;
   logic [NUM_CH-1:0]         i_delta_valid;
   logic [NUM_CH-1:0]         i_enable;
   logic [NUM_CH-1:0]         i_sync;
   logic [PHASE_W-1:0]        o_phase;
   logic [1:0]                o_phase_ch;
   logic                      o_phase_valid;
   logic [NUM_CH-1:0]         o_wrap_stb;
`ifdef SHARED_PHASE_FRAME_STB_EN
   logic                      o_frame_stb;
`endif

   shared_phase_scheduler #(.NUM_CH(NUM_CH), .PHASE_W(PHASE_W)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_phase_delta (i_phase_delta),
      .i_delta_valid (i_delta_valid),
      .i_enable      (i_enable),
      .i_sync        (i_sync),
      .o_phase       (o_phase),
      .o_phase_ch    (o_phase_ch),
      .o_phase_valid (o_phase_valid),
`ifdef SHARED_PHASE_FRAME_STB_EN
      .o_wrap_stb    (o_wrap_stb),
      .o_frame_stb   (o_frame_stb)
`else
      .o_wrap_stb    (o_wrap_stb)
`endif
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;

   // Reference model: per-channel phase/delta/pending-sync plus the visiting slot.
   logic [31:0] m_phase [NUM_CH];
   logic [31:0] m_delta [NUM_CH];
   logic [3:0]  m_pend;
   int          m_slot;
   logic [31:0] exp_phase;
   logic [1:0]  exp_ch;
   logic        exp_valid;
   logic [3:0]  exp_wrap;
   logic        exp_frame;

   task automatic model_reset();
      for (int k = 0; k < NUM_CH; k++) begin
         m_phase[k] = '0;
         m_delta[k] = '0;
      end
      m_pend = '0; m_slot = 0;
      exp_phase = '0; exp_ch = '0; exp_valid = 1'b0; exp_wrap = '0; exp_frame = 1'b0;
   endtask

   task automatic model_step();
      int c;
      logic s;
      longint unsigned total;
      c = m_slot;
      s = m_pend[c] | i_sync[c];
      exp_wrap  = '0;
      exp_valid = i_enable[c];
      exp_frame = (c == 0);
      if (s) begin
         m_phase[c] = '0;
         if (i_enable[c]) begin exp_phase = '0; exp_ch = 2'(c); end
      end else if (i_enable[c]) begin
         total = 64'(m_phase[c]) + 64'(m_delta[c]);
         m_phase[c] = total[31:0];
         exp_phase = m_phase[c];
         exp_ch = 2'(c);
         if (total >= 64'h1_0000_0000) exp_wrap[c] = 1'b1;
      end
      m_pend = m_pend | i_sync;
      if (s) m_pend[c] = 1'b0;
      for (int k = 0; k < NUM_CH; k++)
         if (i_delta_valid[k]) m_delta[k] = i_phase_delta[k*PHASE_W +: PHASE_W];
      m_slot = (c + 1) % NUM_CH;
   endtask

   task automatic check_all(input string tag);
      checks++;
      assert (o_phase === exp_phase) else begin
         errors++; $error("FAIL %s phase obs=%h exp=%h", tag, o_phase, exp_phase); end
      checks++;
      assert (o_phase_ch === exp_ch) else begin
         errors++; $error("FAIL %s phase_ch obs=%0d exp=%0d", tag, o_phase_ch, exp_ch); end
      checks++;
      assert (o_phase_valid === exp_valid) else begin
         errors++; $error("FAIL %s valid obs=%b exp=%b", tag, o_phase_valid, exp_valid); end
      checks++;
      assert (o_wrap_stb === exp_wrap) else begin
         errors++; $error("FAIL %s wrap obs=%b exp=%b", tag, o_wrap_stb, exp_wrap); end
      checks++;
      assert ($onehot0(o_wrap_stb)) else begin
         errors++; $error("FAIL %s wrap_onehot obs=%b exp=onehot0", tag, o_wrap_stb); end
`ifdef SHARED_PHASE_FRAME_STB_EN
      checks++;
      assert (o_frame_stb === exp_frame) else begin
         errors++; $error("FAIL %s frame obs=%b exp=%b", tag, o_frame_stb, exp_frame); end
`endif
   endtask

   task automatic lit_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++; $error("FAIL %s obs=%h exp=%h", tag, obs, exp); end
   endtask

   task automatic tick(input string tag);
      @(posedge i_clk);
      if (!i_rst_n) model_reset();
      else model_step();
      #1;
      check_all(tag);
   endtask

   initial begin
      i_rst_n = 1'b0; i_phase_delta = '0; i_delta_valid = '0; i_enable = '0; i_sync = '0;
      model_reset();
      #1;
      check_all("reset_t0");
      repeat (3) tick("reset_hold");

      // Release away from the edge with all channels enabled; slot 0 runs at the first edge.
      i_rst_n = 1'b1;
      i_enable = 4'hF;
      for (int e = 1; e <= 20; e++) begin
         i_delta_valid = (e == 1) ? 4'hF : 4'h0;
         i_phase_delta = {32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFFF, 32'h4000_0000};
         i_sync = (e == 15) ? 4'b0100 : 4'b0000;
         tick("directed");
         case (e)
            1:  begin lit_check("first_valid", 32'(o_phase_valid), 32'd1);
                      lit_check("first_ch", 32'(o_phase_ch), 32'd0); end
            2:  begin lit_check("ch1_first", o_phase, 32'hFFFF_FFFF);
                      lit_check("ch1_first_wrap", 32'(o_wrap_stb), 32'h0); end
            5:  lit_check("ch0_v1", o_phase, 32'h4000_0000);
            6:  begin lit_check("ch1_dec", o_phase, 32'hFFFF_FFFE);
                      lit_check("ch1_wrap", 32'(o_wrap_stb), 32'h2); end
            9:  lit_check("ch0_v2", o_phase, 32'h8000_0000);
            13: lit_check("ch0_v3", o_phase, 32'hC000_0000);
            15: begin lit_check("ch2_sync", o_phase, 32'h0);
                      lit_check("ch2_sync_wrap", 32'(o_wrap_stb), 32'h0); end
            17: begin lit_check("ch0_v4", o_phase, 32'h0);
                      lit_check("ch0_wrap", 32'(o_wrap_stb), 32'h1); end
            19: lit_check("ch2_after_sync", o_phase, 32'h8000_0000);
            default: ;
         endcase
      end

      // ch3 held off for three of its visits, then resumes from the held phase.
      i_sync = '0; i_delta_valid = '0;
      for (int e = 0; e < 20; e++) begin
         i_enable = (e < 12) ? 4'b0111 : 4'hF;
         tick("ch3_enable");
      end

      for (int e = 0; e < 400; e++) begin
         for (int k = 0; k < NUM_CH; k++) begin
            case ($urandom_range(0, 3))
               0: i_phase_delta[k*PHASE_W +: PHASE_W] = 32'h0;
               1: i_phase_delta[k*PHASE_W +: PHASE_W] = 32'hFFFF_FFFF;
               default: i_phase_delta[k*PHASE_W +: PHASE_W] = $urandom;
            endcase
         end
         i_delta_valid = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         i_enable = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         i_sync = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
         tick("random");
      end

      // Mid-run reset with a pending sync and freshly loaded deltas.
      i_enable = 4'hF; i_sync = 4'b1000; i_delta_valid = 4'hF;
      i_phase_delta = {32'h9000_0000, 32'hA000_0000, 32'hB000_0000, 32'hC000_0000};
      tick("pre_reset");
      i_sync = '0; i_delta_valid = '0;
      i_rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_reset");
      repeat (2) tick("mid_reset_hold");
      i_rst_n = 1'b1;
      for (int e = 0; e < 16; e++) begin
         tick("post_reset");
         lit_check("post_reset_nowrap", 32'(o_wrap_stb), 32'h0);
         lit_check("post_reset_phase", o_phase, 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
